// File: rtl/fsm_calibration_seq.sv
// Calibration trigger sequencer: start -> wait for frame-grabber pulse -> open delay -> staggered per-channel pulses, repeated per scenario.
// Optional WAIT_FG watchdog with ERROR state is compiled in with `define FSM_CAL_TIMEOUT_EN.
module fsm_calibration_seq #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int REP_W = 8
) (
  input  logic             clock,
  input  logic             reset_signal,
  input  logic             start_signal,
  input  logic             fg_signal,
  input  logic             abort_signal,
  input  logic [CNT_W-1:0] fg_open_delay,
  input  logic [CNT_W-1:0] trigger_len,
  input  logic [CNT_W-1:0] ch_spacing,
  input  logic [N_CH-1:0]  ch_enable,
  input  logic [REP_W-1:0] repeat_count,
  input  logic [CNT_W-1:0] fg_timeout,
  output logic [N_CH-1:0]  output_trigger,
  output logic [3:0]       scenario_state,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] shot_count,
  output logic             timeout_flag
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_FG   = 3'd1,
    S_WAIT_OPEN = 3'd2,
    S_PULSE     = 3'd3,
    S_DONE      = 3'd4,
    S_ERROR     = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [REP_W-1:0] REP_ZERO = {REP_W{1'b0}};
  localparam logic [REP_W-1:0] REP_ONE  = {{(REP_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum_v;
    sum_v = {1'b0, a} + {1'b0, b};
    if (sum_v[CNT_W]) begin
      sat_add = {CNT_W{1'b1}};
    end else begin
      sat_add = sum_v[CNT_W-1:0];
    end
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       start_hist_q, fg_hist_q;
  logic             start_rise_s, fg_rise_s, load_s;
  logic [CNT_W-1:0] delay_q, len_q, sp_q;
  logic [N_CH-1:0]  en_q;
  logic [REP_W-1:0] rep_q, shot_q, shot_d, shot_inc_s;
  logic             tflag_q, tflag_d;
  logic [N_CH-1:0]  trig_q, trig_d;
  logic             done_q, done_d, busy_q, busy_d;
  logic [CNT_W-1:0] off_s [N_CH];
  logic [CNT_W-1:0] end_s [N_CH];
  logic [CNT_W-1:0] pulse_last_s;

`ifdef FSM_CAL_TIMEOUT_EN
  logic [CNT_W-1:0] to_q;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^fg_timeout;
`endif

  // History holds {previous, current} sample; 01 marks a fresh rise
  assign start_rise_s = (start_hist_q == 2'b01);
  assign fg_rise_s    = (fg_hist_q == 2'b01);
  assign shot_inc_s   = (&shot_q) ? shot_q : shot_q + REP_ONE;
  assign pulse_last_s = end_s[N_CH-1] - CNT_ONE;

  // Channel windows: start offsets accumulated by repeated saturating adds of the spacing
  always_comb begin : window_calc
    logic [CNT_W-1:0] acc_v;
    acc_v = CNT_ZERO;
    for (int i = 0; i < N_CH; i++) begin
      off_s[i] = acc_v;
      end_s[i] = sat_add(acc_v, len_q);
      acc_v    = sat_add(acc_v, sp_q);
    end
  end

  // Next-state, counter, shot and output computation
  always_comb begin
    state_d = state_q;
    cnt_d   = sat_add(cnt_q, CNT_ONE);
    shot_d  = shot_q;
    tflag_d = tflag_q;
    load_s  = 1'b0;
    if (abort_signal) begin
      state_d = S_IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = CNT_ZERO;
          if (start_rise_s) begin
            load_s  = 1'b1;
            shot_d  = REP_ZERO;
            tflag_d = 1'b0;
            state_d = S_WAIT_FG;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WAIT_FG: begin
          if (fg_rise_s) begin
            state_d = S_WAIT_OPEN;
            cnt_d   = CNT_ZERO;
`ifdef FSM_CAL_TIMEOUT_EN
          end else if (cnt_q >= to_q - CNT_ONE) begin
            state_d = S_ERROR;
            tflag_d = 1'b1;
            cnt_d   = CNT_ZERO;
`endif
          end else begin
            state_d = S_WAIT_FG;
          end
        end
        S_WAIT_OPEN: begin
          if (cnt_q >= delay_q) begin
            state_d = S_PULSE;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = S_WAIT_OPEN;
          end
        end
        S_PULSE: begin
          if (cnt_q >= pulse_last_s) begin
            shot_d = shot_inc_s;
            cnt_d  = CNT_ZERO;
            if (shot_inc_s < rep_q) begin
              state_d = S_WAIT_FG;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            state_d = S_PULSE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
        end
        S_ERROR: begin
          cnt_d = CNT_ZERO;
`ifdef FSM_CAL_TIMEOUT_EN
          if (start_rise_s) begin
            load_s  = 1'b1;
            shot_d  = REP_ZERO;
            tflag_d = 1'b0;
            state_d = S_WAIT_FG;
          end else begin
            state_d = S_ERROR;
          end
`else
          state_d = S_IDLE;
`endif
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end

    trig_d = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      trig_d[i] = en_q[i] && (state_d == S_PULSE) && (cnt_d >= off_s[i]) && (cnt_d < end_s[i]);
    end
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // State, configuration latch and registered outputs
  always_ff @(posedge clock) begin
    if (reset_signal) begin
      state_q      <= S_IDLE;
      cnt_q        <= CNT_ZERO;
      start_hist_q <= 2'b00;
      fg_hist_q    <= 2'b00;
      delay_q      <= CNT_ZERO;
      len_q        <= CNT_ONE;
      sp_q         <= CNT_ZERO;
      en_q         <= {N_CH{1'b0}};
      rep_q        <= REP_ONE;
      shot_q       <= REP_ZERO;
      tflag_q      <= 1'b0;
      trig_q       <= {N_CH{1'b0}};
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
`ifdef FSM_CAL_TIMEOUT_EN
      to_q         <= CNT_ONE;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_hist_q <= {start_hist_q[0], start_signal};
      fg_hist_q    <= {fg_hist_q[0], fg_signal};
      shot_q       <= shot_d;
      tflag_q      <= tflag_d;
      trig_q       <= trig_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      if (load_s) begin
        delay_q <= fg_open_delay;
        len_q   <= (trigger_len == CNT_ZERO) ? CNT_ONE : trigger_len;
        sp_q    <= ch_spacing;
        en_q    <= ch_enable;
        rep_q   <= (repeat_count == REP_ZERO) ? REP_ONE : repeat_count;
`ifdef FSM_CAL_TIMEOUT_EN
        to_q    <= (fg_timeout == CNT_ZERO) ? CNT_ONE : fg_timeout;
`endif
      end
    end
  end

  assign output_trigger = trig_q;
  assign scenario_state = {1'b0, state_q};
  assign busy           = busy_q;
  assign done           = done_q;
  assign shot_count     = shot_q;
`ifdef FSM_CAL_TIMEOUT_EN
  assign timeout_flag   = tflag_q;
`else
  assign timeout_flag   = 1'b0;
`endif

endmodule
